// File: rtl/usb_rx_crc_checker.sv
// Serial CRC5/CRC16 verifier for the USB receive path. Accumulates de-stuffed
// payload bits and produces a registered pass/fail verdict on request.
module usb_rx_crc_checker #(
  parameter int unsigned    CNT_W = 11,
  parameter logic [4:0]     RES5  = 5'b01100,
  parameter logic [15:0]    RES16 = 16'h800D
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_i,
  input  logic             crc_enable_i,
  input  logic             shift_enable_i,
  input  logic             d_orig_i,
  input  logic             crc_check_5_i,
  input  logic             crc_check_16_i,
  output logic [1:0]       crc_status_o,
  output logic [CNT_W-1:0] bit_count_o
);

  localparam logic [1:0] StatusPending = 2'b00;
  localparam logic [1:0] StatusPass    = 2'b01;
  localparam logic [1:0] StatusFail    = 2'b10;

  typedef enum logic [0:0] {StAccum, StVerdict} state_e;

  state_e           state_q, state_d;
  logic [4:0]       crc5_q, crc5_d;
  logic [15:0]      crc16_q, crc16_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       status_q, status_d;

  logic fb5, fb16, pass5, pass16;

  assign fb5  = d_orig_i ^ crc5_q[4];
  assign fb16 = d_orig_i ^ crc16_q[15];

  // Token: 11 address/endpoint bits plus 5 CRC bits, exactly.
  assign pass5  = (crc5_q == RES5) && (cnt_q == CNT_W'(16));
  // Data: whole bytes only, at least the 16 CRC bits.
  assign pass16 = (crc16_q == RES16) && (cnt_q >= CNT_W'(16)) && (cnt_q[2:0] == 3'b000);

  always_comb begin
    state_d  = state_q;
    crc5_d   = crc5_q;
    crc16_d  = crc16_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    if (clear_i) begin
      state_d  = StAccum;
      crc5_d   = 5'h1F;
      crc16_d  = 16'hFFFF;
      cnt_d    = '0;
      status_d = StatusPending;
    end else if (state_q == StAccum) begin
      if (crc_check_5_i || crc_check_16_i) begin
        // Verdict uses pre-shift values; any coincident shift is dropped.
        state_d = StVerdict;
        if (crc_check_5_i && crc_check_16_i) begin
          status_d = StatusFail;
        end else if (crc_check_5_i) begin
          status_d = pass5 ? StatusPass : StatusFail;
        end else begin
          status_d = pass16 ? StatusPass : StatusFail;
        end
      end else if (crc_enable_i && shift_enable_i) begin
        crc5_d  = {crc5_q[3:0], 1'b0} ^ (fb5 ? 5'h05 : 5'h00);
        crc16_d = {crc16_q[14:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000);
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StAccum;
      crc5_q   <= 5'h1F;
      crc16_q  <= 16'hFFFF;
      cnt_q    <= '0;
      status_q <= StatusPending;
    end else begin
      state_q  <= state_d;
      crc5_q   <= crc5_d;
      crc16_q  <= crc16_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  assign crc_status_o = status_q;
  assign bit_count_o  = cnt_q;

endmodule

// File: tb/tb_usb_rx_crc_checker.sv
// Directed bench for usb_rx_crc_checker: token and data packets, gating,
// length rules, verdict hold, clear priority, saturation and async reset.
module tb_usb_rx_crc_checker;

  localparam int unsigned CNT_W = 11;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             clear;
  logic             crc_enable;
  logic             shift_enable;
  logic             d_orig;
  logic             crc_check_5;
  logic             crc_check_16;
  logic [1:0]       crc_status;
  logic [CNT_W-1:0] bit_count;

  int total = 0;
  int bad   = 0;

  // Token OUT addr 0 endp 0: bytes 0x00, 0x10, sent LSB first -> bit i of this word.
  localparam logic [15:0] TokGood = 16'h1000;

  usb_rx_crc_checker #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear_i        (clear),
    .crc_enable_i   (crc_enable),
    .shift_enable_i (shift_enable),
    .d_orig_i       (d_orig),
    .crc_check_5_i  (crc_check_5),
    .crc_check_16_i (crc_check_16),
    .crc_status_o   (crc_status),
    .bit_count_o    (bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic shift_bits(input logic [15:0] data, input int n, input logic en);
    for (int i = 0; i < n; i++) begin
      crc_enable   = en;
      shift_enable = 1'b1;
      d_orig       = data[i];
      @(negedge clk);
    end
    shift_enable = 1'b0;
    d_orig       = 1'b0;
  endtask

  task automatic do_check(input logic c5, input logic c16);
    crc_check_5  = c5;
    crc_check_16 = c16;
    @(negedge clk);
    crc_check_5  = 1'b0;
    crc_check_16 = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; crc_enable = 1'b0; shift_enable = 1'b0;
    d_orig = 1'b0; crc_check_5 = 1'b0; crc_check_16 = 1'b0;
    #12;
    chk("reset_status", 32'(crc_status), 32'h0);
    chk("reset_count", 32'(bit_count), 32'h0);
    n_rst = 1'b1;
    @(negedge clk);

    // Good token
    do_clear();
    shift_bits(TokGood, 16, 1'b1);
    chk("tok_count", 32'(bit_count), 32'd16);
    chk("tok_pending", 32'(crc_status), 32'h0);
    do_check(1'b1, 1'b0);
    chk("tok_pass", 32'(crc_status), 32'h1);

    // Corrupted token; verdict holds while strobes continue
    do_clear();
    chk("clear_status", 32'(crc_status), 32'h0);
    shift_bits(TokGood ^ 16'h1000, 16, 1'b1);
    do_check(1'b1, 1'b0);
    chk("tok_bad", 32'(crc_status), 32'h2);
    shift_bits(16'hA5A5, 16, 1'b1);
    crc_check_16 = 1'b1;
    repeat (4) @(negedge clk);
    crc_check_16 = 1'b0;
    chk("hold_status", 32'(crc_status), 32'h2);
    chk("hold_count", 32'(bit_count), 32'd16);

    // DATA0, zero-length payload
    do_clear();
    shift_bits(16'h0000, 16, 1'b1);
    do_check(1'b0, 1'b1);
    chk("data0_pass", 32'(crc_status), 32'h1);
    do_clear();
    shift_bits(16'h0000, 16, 1'b1);
    shift_bits(16'h0000, 1, 1'b1);
    chk("data17_count", 32'(bit_count), 32'd17);
    do_check(1'b0, 1'b1);
    chk("data17_fail", 32'(crc_status), 32'h2);

    // Gated SYNC/PID bits, then valid token; check with coincident shift
    do_clear();
    shift_bits(16'h8D1E, 16, 1'b0);
    chk("gated_count", 32'(bit_count), 32'd0);
    shift_bits(TokGood, 16, 1'b1);
    crc_enable = 1'b1; shift_enable = 1'b1; d_orig = 1'b1;
    do_check(1'b1, 1'b0);
    shift_enable = 1'b0; d_orig = 1'b0;
    chk("gated_pass", 32'(crc_status), 32'h1);
    chk("gated_count16", 32'(bit_count), 32'd16);
    shift_enable = 1'b1;
    do_check(1'b1, 1'b1);
    shift_enable = 1'b0;
    chk("verdict_frozen", 32'(crc_status), 32'h1);

    // Both checks at once
    do_clear();
    shift_bits(TokGood, 16, 1'b1);
    do_check(1'b1, 1'b1);
    chk("both_fail", 32'(crc_status), 32'h2);

    // Clear beats a coincident shift; LFSRs reinitialised (proved by good token)
    shift_enable = 1'b1; d_orig = 1'b1;
    do_clear();
    shift_enable = 1'b0; d_orig = 1'b0;
    chk("clr_count", 32'(bit_count), 32'd0);
    chk("clr_status", 32'(crc_status), 32'h0);
    shift_bits(TokGood, 16, 1'b1);
    do_check(1'b1, 1'b0);
    chk("clr_tok_pass", 32'(crc_status), 32'h1);

    // Saturating counter fails CRC5
    do_clear();
    for (int i = 0; i < 2100; i++) shift_bits(16'h0001, 1, 1'b1);
    chk("sat_count", 32'(bit_count), 32'd2047);
    do_check(1'b1, 1'b0);
    chk("sat_fail5", 32'(crc_status), 32'h2);

    // Async reset mid-packet
    do_clear();
    shift_bits(TokGood, 7, 1'b1);
    chk("pre_rst_count", 32'(bit_count), 32'd7);
    #2 n_rst = 1'b0;
    #1;
    chk("rst_mid_count", 32'(bit_count), 32'd0);
    chk("rst_mid_status", 32'(crc_status), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    shift_bits(TokGood, 16, 1'b1);
    do_check(1'b1, 1'b0);
    chk("post_rst_pass", 32'(crc_status), 32'h1);
    chk("post_rst_count", 32'(bit_count), 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_rx_crc_checker.md
Name: usb_rx_crc_checker

Overview:
- Serial CRC verifier for the USB RX path.
- Accumulates de-stuffed, NRZI-decoded payload bits after the PID into parallel CRC5 and CRC16 LFSRs.
- Returns a pass/fail verdict on crc_status when the receiver control unit raises crc_check_5 or crc_check_16 after EOP.
- Sits between the bit decoder / shift timer (source of d_orig, shift_enable) and the receiver control unit (consumer of crc_status).

Parameters:
CNT_W, 11, width of the saturating received-bit counter; max count 2^CNT_W-1.
RES5, 5'b01100, CRC5 good-packet residual.
RES16, 16'h800D, CRC16 good-packet residual.

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
clear  in  1  synchronous packet restart, driven by the control unit while idle
crc_enable  in  1  data phase active (control unit load_data); gates accumulation
shift_enable  in  1  one-cycle strobe: d_orig holds a valid de-stuffed bit
d_orig  in  1  decoded serial bit, USB order (LSB of each byte first)
crc_check_5  in  1  request CRC5 verdict (token packet)
crc_check_16  in  1  request CRC16 verdict (data packet)
crc_status  out  2  00 pending, 01 pass, 10 fail; 11 never driven
bit_count  out  CNT_W  bits accumulated since last clear (debug/verification)

Behaviour:
- Reset (n_rst low, async):
  - crc5 <= 5'h1F, crc16 <= 16'hFFFF, bit_count <= 0, crc_status <= 00, FSM <= ACCUM.
- Shift rule (ACCUM state, crc_enable && shift_enable):
  - CRC5: fb = d_orig ^ crc5[4]; crc5 <= {crc5[3:0],1'b0} ^ (fb ? 5'h05 : 0).
  - CRC16: fb = d_orig ^ crc16[15]; crc16 <= {crc16[14:0],1'b0} ^ (fb ? 16'h8005 : 0).
  - Both LFSRs shift every qualified bit.
  - bit_count increments, saturating at all-ones.
  - shift_enable without crc_enable is ignored; this covers SYNC/PID bits and SE0.
- FSM states: ACCUM, VERDICT.
- ACCUM -> VERDICT on the first cycle either check input is high.
  - The verdict uses the register values before any shift in that same cycle; a coincident shift is discarded.
  - crc_status is registered, valid from the next rising edge.
- CRC5 pass condition: crc5 == RES5 and bit_count == 16 (11-bit addr/endp + 5-bit CRC). Otherwise fail (10).
- CRC16 pass condition: crc16 == RES16, bit_count >= 16, and bit_count[2:0] == 0. Otherwise fail.
- Both check inputs high in the same cycle: fail (10).
- Saturated bit_count: treated as a normal value. It fails CRC5; CRC16 is evaluated under the normal rules.
- VERDICT state:
  - crc_status held; LFSRs and bit_count frozen; check and shift inputs ignored.
  - Exit only via clear or reset.
- clear (any state):
  - Next edge: LFSRs to all ones, bit_count 0, crc_status 00, FSM to ACCUM.
  - clear has priority over shift and check in the same cycle.
- Latency: check asserted at edge N -> crc_status valid after edge N+1. The control unit spins in its CHECK state until status is non-zero.
- Reset mid-packet: immediate return to reset values; no verdict produced.

Test Plan:
- Token OUT addr 0 endp 0: after clear, crc_enable=1, shift bits of bytes 0x00, 0x10 LSB-first (16 strobes), then crc_check_5 -> crc_status 01 one cycle later, bit_count 16.
- Same token with bit 12 inverted -> crc_status 10; status holds 10 for 20 cycles with further shift strobes, bit_count stays 16.
- DATA0 zero-length payload: shift 0x00, 0x00 (16 bits), crc_check_16 -> 01. Shift 0x00 0x00 plus one extra bit (17 bits) -> 10 from the length rule.
- Gating: 16 shift strobes with crc_enable=0 before the payload, then the valid token bits with crc_enable=1 -> 01, bit_count 16; check and shift asserted in the same cycle do not change the verdict.
- Simultaneous crc_check_5 and crc_check_16 on a valid token stream -> 10. clear asserted with shift_enable in the same cycle -> bit_count 0, status 00, LFSRs all ones.
- n_rst pulsed low after 7 payload bits -> outputs return to reset values immediately. The following full token packet -> 01.
